// File: rtl/comp_serial_msb.sv
// comp_serial_msb: bit-serial MSB-first unsigned magnitude comparator with valid/ready handshakes
module comp_serial_msb #(
  parameter int WIDTH = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             busy
);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0] idx, idx_d;
  logic gt_d, eq_d, lt_d, found, found_d, bit_gt, bit_lt, last;
  assign in_ready  = state == IDLE;
  assign busy      = state == SCAN;
  assign out_valid = state == DONE;
  assign bit_gt = a_q[idx] & ~b_q[idx];
  assign bit_lt = ~a_q[idx] & b_q[idx];
  assign last = idx == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      idx <= '0;
      gt <= 1'b0;
      eq <= 1'b0;
      lt <= 1'b0;
      found <= 1'b0;
    end else begin
      state <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      idx <= idx_d;
      gt <= gt_d;
      eq <= eq_d;
      lt <= lt_d;
      found <= found_d;
    end
  end
  always_comb begin
    state_d = state;
    a_d = a_q;
    b_d = b_q;
    idx_d = idx;
    gt_d = gt;
    eq_d = eq;
    lt_d = lt;
    found_d = found;
    case (state)
      IDLE: if (in_valid) begin
        a_d = a;
        b_d = b;
        idx_d = IW'(WIDTH - 1);
        {gt_d, eq_d, lt_d, found_d} = 4'b0;
        state_d = SCAN;
      end
      SCAN: if (EARLY_EXIT) begin
        if (bit_gt | bit_lt) begin
          gt_d = bit_gt;
          lt_d = bit_lt;
          state_d = DONE;
        end else if (last) begin
          eq_d = 1'b1;
          state_d = DONE;
        end else idx_d = idx - 1'b1;
      end else begin
        // first differing bit from the top wins; lower bits cannot override it
        if (!found && (bit_gt | bit_lt)) begin
          found_d = 1'b1;
          gt_d = bit_gt;
          lt_d = bit_lt;
        end
        if (last) begin
          eq_d = !found && !(bit_gt | bit_lt);
          state_d = DONE;
        end else idx_d = idx - 1'b1;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_comp_serial_msb.sv
// tb_comp_serial_msb: directed checks of early-exit and fixed-latency comparator instances
module tb_comp_serial_msb;
  logic clk = 1'b0, rst_n = 1'b0, out_ready = 1'b0, iv_e = 1'b0, iv_f = 1'b0, sel = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic ir_e, ov_e, gt_e, eq_e, lt_e, bz_e, ir_f, ov_f, gt_f, eq_f, lt_f, bz_f;
  logic c_ir, c_ov, c_bz;
  logic [2:0] c_gel;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  comp_serial_msb #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_e (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_e), .in_ready(ir_e), .a(a), .b(b),
    .out_valid(ov_e), .out_ready(out_ready), .gt(gt_e), .eq(eq_e), .lt(lt_e), .busy(bz_e));
  comp_serial_msb #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_f (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_f), .in_ready(ir_f), .a(a), .b(b),
    .out_valid(ov_f), .out_ready(out_ready), .gt(gt_f), .eq(eq_f), .lt(lt_f), .busy(bz_f));
  assign c_ir = sel ? ir_f : ir_e;
  assign c_ov = sel ? ov_f : ov_e;
  assign c_bz = sel ? bz_f : bz_e;
  assign c_gel = sel ? {gt_f, eq_f, lt_f} : {gt_e, eq_e, lt_e};
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run(input bit fx, input logic [7:0] av, input logic [7:0] bv,
                     input int lat, input logic [2:0] gel, input bit noise, input string tag);
    int n = 0, bc = 0;
    sel = fx;
    @(negedge clk);
    a = av;
    b = bv;
    if (fx) iv_f = 1'b1; else iv_e = 1'b1;
    @(posedge clk);
    #1 iv_e = 1'b0;
    iv_f = 1'b0;
    while (n < 20) begin
      @(negedge clk);
      if (c_ov) break;
      bc += int'(c_bz);
      if (noise) begin
        a = 8'($urandom);
        b = 8'($urandom);
        iv_e = 1'b1;
      end
      @(posedge clk);
      n++;
    end
    iv_e = 1'b0;
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_busy"}, bc, lat);
    chk({tag, "_gel"}, int'(c_gel), int'(gel));
  endtask
  task automatic hand(input logic [2:0] gel, input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_idle"}, int'({c_ir, c_ov, c_bz}), 3'b100);
    chk({tag, "_keep"}, int'(c_gel), int'(gel));
  endtask
  initial begin
    int hold_bad;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_e", int'({ir_e, ov_e, gt_e, eq_e, lt_e, bz_e}), 6'b100000);
    chk("rst_f", int'({ir_f, ov_f, gt_f, eq_f, lt_f, bz_f}), 6'b100000);
    run(1'b0, 8'h80, 8'h7F, 1, 3'b100, 1'b0, "msb_gt");
    hand(3'b100, "msb_gt");
    run(1'b0, 8'hA5, 8'hA5, 8, 3'b010, 1'b0, "eq_a5");
    hand(3'b010, "eq_a5");
    run(1'b0, 8'h12, 8'h13, 8, 3'b001, 1'b0, "lsb_lt");
    hand(3'b001, "lsb_lt");
    run(1'b1, 8'hF0, 8'h0F, 8, 3'b100, 1'b0, "fix_gt");
    hand(3'b100, "fix_gt");
    run(1'b1, 8'h33, 8'h33, 8, 3'b010, 1'b0, "fix_eq");
    hand(3'b010, "fix_eq");
    run(1'b1, 8'h01, 8'h03, 8, 3'b001, 1'b0, "fix_lt");
    hand(3'b001, "fix_lt");
    run(1'b0, 8'h05, 8'h09, 5, 3'b001, 1'b1, "bp_lt");
    hold_bad = 0;
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      iv_e = i[0];
      @(negedge clk);
      if (!(ov_e && {gt_e, eq_e, lt_e} == 3'b001)) hold_bad++;
    end
    iv_e = 1'b0;
    chk("bp_hold", hold_bad, 0);
    hand(3'b001, "bp_lt");
    chk("bp_no_reaccept", int'(bz_e), 0);
    sel = 1'b0;
    @(negedge clk);
    a = 8'hFF;
    b = 8'hFF;
    iv_e = 1'b1;
    @(posedge clk);
    #1 iv_e = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid", int'({ir_e, ov_e, gt_e, eq_e, lt_e, bz_e}), 6'b100000);
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b0, 8'h01, 8'h00, 8, 3'b100, 1'b0, "post_rst");
    hand(3'b100, "post_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
